// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: command words, R1 codes, error codes, status layout and states for the SD sequencer
package sd_cmd_pkg;
   localparam logic [2:0]  INIT_DIV        = 3'b100;
   localparam logic [2:0]  FAST_DIV        = 3'b001;
   localparam logic [15:0] RETRY_MAX_DEF   = 16'd1000;
   localparam logic [23:0] TIMEOUT_CYC_DEF = 24'hFFFFFF;
   localparam logic [47:0] CMD_DUMMY = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] CMD0_W    = 48'h40_0000_0000_95;
   localparam logic [47:0] CMD8_W    = 48'h48_0000_01AA_87;
   localparam logic [47:0] CMD55_W   = 48'h77_0000_0000_65;
   localparam logic [47:0] ACMD41_W  = 48'h69_4000_0000_77;
   localparam logic [7:0]  CMD17_IDX = 8'h51;
   localparam logic [7:0]  CMD17_CRC = 8'hFF;
   localparam logic [7:0]  R1_IDLE   = 8'h01;
   localparam logic [7:0]  R1_READY  = 8'h00;
   localparam logic [2:0]  ERR_NONE      = 3'd0;
   localparam logic [2:0]  ERR_CMD0      = 3'd1;
   localparam logic [2:0]  ERR_CMD8      = 3'd2;
   localparam logic [2:0]  ERR_ACMD41_TO = 3'd3;
   localparam logic [2:0]  ERR_ACMD41_R1 = 3'd4;
   localparam logic [2:0]  ERR_CMD17     = 3'd5;
   localparam logic [2:0]  ERR_TIMEOUT   = 3'd6;
   localparam int STAT_OP  = 0;
   localparam int STAT_SS  = 1;
   localparam int STAT_FBO = 2;
   localparam int STAT_WR  = 3;
   localparam int STAT_RD  = 4;
   localparam int STAT_DIV = 5;

   typedef enum logic [3:0] {
      S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_READY, S_RD, S_ERROR
   } sd_state_e;

   typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_EVAL} sd_phase_e;

   function automatic logic [47:0] state_cmd(input sd_state_e s, input logic [31:0] addr);
      return s == S_CMD0   ? CMD0_W   :
             s == S_CMD8   ? CMD8_W   :
             s == S_CMD55  ? CMD55_W  :
             s == S_ACMD41 ? ACMD41_W :
             s == S_RD     ? {CMD17_IDX, addr, CMD17_CRC} : CMD_DUMMY;
   endfunction

   function automatic logic [7:0] status_word(input logic [2:0] div, input logic ss, wr, rd, op);
      logic [7:0] s;
      s = '0;
      s[STAT_OP]      = op;
      s[STAT_SS]      = ss;
      s[STAT_FBO]     = 1'b1;
      s[STAT_WR]      = wr;
      s[STAT_RD]      = rd;
      s[STAT_DIV+:3]  = div;
      return s;
   endfunction
endpackage

// File: rtl/sd_cmd_sequencer_timer.sv
// sd_txn_timer: per-transaction watchdog, flags expiry on the LIMIT-th enabled cycle
module sd_txn_timer #(
   parameter logic [23:0] LIMIT = 24'hFFFFFF
) (
   input  logic spi_clk_i,
   input  logic spi_rst_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   logic [23:0] r_cnt;

   assign o_expired = i_en && r_cnt == LIMIT - 24'd1;

   // count enabled cycles, holding once the limit is hit
   always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
      if (spi_rst_i) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en && !o_expired) r_cnt <= r_cnt + 24'd1;
   end
endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: SD SPI-mode power-up/init sequence and single-block read command driver
module sd_cmd_sequencer
   import sd_cmd_pkg::*;
#(
   parameter logic [15:0] RETRY_MAX   = RETRY_MAX_DEF,
   parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        spi_clk_i,
   input  logic        spi_rst_i,
   input  logic        start_i,
   input  logic        rd_req_i,
   input  logic [31:0] rd_addr_i,
   output logic [47:0] spi_cmd_o,
   output logic [7:0]  spi_status_o,
   output logic        spi_enable_o,
   input  logic [7:0]  spi_r1_i,
   input  logic [2:0]  spi_flag_i,
   input  logic [31:0] spi_data_i,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   output logic        busy_o,
   output logic        init_done_o,
   output logic        error_o,
   output logic [2:0]  err_code_o
);
   sd_state_e   r_state, w_state;
   sd_phase_e   r_phase, w_phase;
   logic [47:0] r_cmd, w_cmd;
   logic [7:0]  r_status, w_status;
   logic        r_enable, w_enable;
   logic [31:0] r_rd_data, w_rd_data;
   logic        r_rd_valid, w_rd_valid;
   logic        r_busy, w_busy;
   logic        r_init_done, w_init_done;
   logic        r_error, w_error;
   logic [2:0]  r_err_code, w_err_code, w_fail_code;
   logic [15:0] r_retry, w_retry;
   logic [31:0] r_addr, w_addr;
   logic [1:0]  r_flag_q;
   logic [7:0]  r_r1;
   logic        w_active, w_done_rise, w_word_rise, w_expired, w_unused;

   assign w_active    = r_state inside {S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_RD};
   assign w_done_rise = spi_flag_i[1] & ~r_flag_q[1];
   assign w_word_rise = spi_flag_i[0] & ~r_flag_q[0];
   assign w_unused    = spi_flag_i[2];

   sd_txn_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
      .spi_clk_i (spi_clk_i),
      .spi_rst_i (spi_rst_i),
      .i_clr     (w_active && r_phase == PH_ISSUE),
      .i_en      (w_active && r_phase == PH_WAIT),
      .o_expired (w_expired)
   );

   // next state, phase and registered-output values
   always_comb begin
      w_state     = r_state;
      w_phase     = r_phase;
      w_cmd       = r_cmd;
      w_status    = r_status;
      w_enable    = r_enable;
      w_rd_data   = r_rd_data;
      w_rd_valid  = 1'b0;
      w_init_done = r_init_done;
      w_error     = r_error;
      w_err_code  = r_err_code;
      w_retry     = r_retry;
      w_addr      = r_addr;
      w_fail_code = ERR_NONE;
      if (start_i && !w_active) begin
         w_state     = S_DUMMY;
         w_phase     = PH_ISSUE;
         w_error     = 1'b0;
         w_err_code  = ERR_NONE;
         w_init_done = 1'b0;
         w_retry     = '0;
         w_status    = status_word(INIT_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (r_state == S_READY) begin
         w_state = rd_req_i ? S_RD : S_READY;
         w_phase = PH_ISSUE;
         w_addr  = rd_req_i ? rd_addr_i : r_addr;
      end else if (w_active && r_phase == PH_ISSUE) begin
         w_cmd    = state_cmd(r_state, r_addr);
         w_status = status_word(r_status[STAT_DIV+:3], r_state == S_DUMMY, 1'b0, r_state == S_RD, 1'b1);
         w_enable = 1'b1;
         w_phase  = PH_WAIT;
      end else if (w_active && r_phase == PH_WAIT) begin
         w_rd_valid  = r_state == S_RD && w_word_rise;
         w_rd_data   = w_rd_valid ? spi_data_i : r_rd_data;
         w_fail_code = ERR_TIMEOUT;
         if (w_done_rise) begin
            w_enable          = 1'b0;
            w_status[STAT_OP] = 1'b0;
            w_phase           = PH_EVAL;
         end else if (w_expired) begin
            w_state = S_ERROR;
         end
      end else if (w_active) begin
         w_phase = PH_ISSUE;
         case (r_state)
            S_DUMMY: w_state = S_CMD0;
            S_CMD0: begin
               w_state     = r_r1 == R1_IDLE ? S_CMD8 : S_ERROR;
               w_fail_code = ERR_CMD0;
            end
            S_CMD8: begin
               w_state     = r_r1 == R1_IDLE ? S_CMD55 : S_ERROR;
               w_fail_code = ERR_CMD8;
            end
            S_CMD55: begin
               w_state     = (r_r1 == R1_IDLE || r_r1 == R1_READY) ? S_ACMD41 : S_ERROR;
               w_fail_code = ERR_ACMD41_R1;
            end
            S_ACMD41: begin
               w_state     = r_r1 == R1_READY ? S_READY :
                             r_r1 != R1_IDLE ? S_ERROR :
                             r_retry == RETRY_MAX - 16'd1 ? S_ERROR : S_CMD55;
               w_fail_code = r_r1 == R1_IDLE ? ERR_ACMD41_TO : ERR_ACMD41_R1;
               w_retry     = w_state == S_CMD55 ? r_retry + 16'd1 : r_retry;
               w_init_done = w_state == S_READY;
               w_status[STAT_DIV+:3] = w_state == S_READY ? FAST_DIV : r_status[STAT_DIV+:3];
            end
            S_RD: begin
               w_state     = r_r1 == R1_READY ? S_READY : S_ERROR;
               w_fail_code = ERR_CMD17;
            end
            default: w_state = r_state;
         endcase
      end
      if (w_state == S_ERROR && r_state != S_ERROR) begin
         w_error           = 1'b1;
         w_err_code        = w_fail_code;
         w_enable          = 1'b0;
         w_status[STAT_OP] = 1'b0;
      end
      w_busy = !(w_state inside {S_IDLE, S_READY, S_ERROR});
   end

   // state register, registered outputs and flag edge history
   always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
      if (spi_rst_i) begin
         r_state     <= S_IDLE;
         r_phase     <= PH_ISSUE;
         r_cmd       <= CMD_DUMMY;
         r_status    <= status_word(INIT_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
         r_enable    <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_init_done <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_retry     <= '0;
         r_addr      <= '0;
         r_flag_q    <= '0;
         r_r1        <= '0;
      end else begin
         r_state     <= w_state;
         r_phase     <= w_phase;
         r_cmd       <= w_cmd;
         r_status    <= w_status;
         r_enable    <= w_enable;
         r_rd_data   <= w_rd_data;
         r_rd_valid  <= w_rd_valid;
         r_busy      <= w_busy;
         r_init_done <= w_init_done;
         r_error     <= w_error;
         r_err_code  <= w_err_code;
         r_retry     <= w_retry;
         r_addr      <= w_addr;
         r_flag_q    <= spi_flag_i[1:0];
         r_r1        <= w_done_rise ? spi_r1_i : r_r1;
      end
   end

   assign spi_cmd_o    = r_cmd;
   assign spi_status_o = r_status;
   assign spi_enable_o = r_enable;
   assign rd_data_o    = r_rd_data;
   assign rd_valid_o   = r_rd_valid;
   assign busy_o       = r_busy;
   assign init_done_o  = r_init_done;
   assign error_o      = r_error;
   assign err_code_o   = r_err_code;
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed bench with a scripted SD card / SPI master model
`timescale 1ns/1ps
module tb_sd_cmd_sequencer;
   localparam logic [47:0] C_DUMMY  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] C_CMD0   = 48'h40_0000_0000_95;
   localparam logic [47:0] C_CMD8   = 48'h48_0000_01AA_87;
   localparam logic [47:0] C_CMD55  = 48'h77_0000_0000_65;
   localparam logic [47:0] C_ACMD41 = 48'h69_4000_0000_77;
   localparam logic [95:0] RST_VEC  = {48'hFFFF_FFFF_FFFF, 8'h84, 8'h00, 32'h0};

   logic        spi_clk_i = 1'b0, spi_rst_i = 1'b0;
   logic        start_i = 1'b0, rd_req_i = 1'b0;
   logic [31:0] rd_addr_i = '0;
   logic [47:0] spi_cmd_o;
   logic [7:0]  spi_status_o, spi_r1_i;
   logic        spi_enable_o, rd_valid_o, busy_o, init_done_o, error_o;
   logic [2:0]  spi_flag_i, err_code_o;
   logic [31:0] spi_data_i, rd_data_o;
   logic [95:0] a_obs;

   logic        b_start = 1'b0, b_rd_req = 1'b0;
   logic [31:0] b_addr = '0, b_data_in = '0;
   logic [7:0]  b_r1 = '0;
   logic [2:0]  b_flag = '0;
   logic [47:0] b_cmd;
   logic [7:0]  b_status;
   logic        b_enable, b_rd_valid, b_busy, b_init_done, b_error;
   logic [2:0]  b_err_code;
   logic [31:0] b_rd_data;

   logic [7:0]  cmd8_r1 = 8'h01;
   int          acmd_fails = 0;
   logic [47:0] cmd_log[$];
   logic [31:0] rd_words[$];
   int          acmd_run;
   int          tests_run = 0, tests_failed = 0;

   assign a_obs = {spi_cmd_o, spi_status_o, spi_enable_o, rd_valid_o, busy_o, init_done_o, error_o, err_code_o, rd_data_o};

   always #5 spi_clk_i = ~spi_clk_i;

   sd_cmd_sequencer #(.RETRY_MAX(16'd4), .TIMEOUT_CYC(24'd2000)) dut (
      .spi_clk_i(spi_clk_i), .spi_rst_i(spi_rst_i), .start_i(start_i), .rd_req_i(rd_req_i),
      .rd_addr_i(rd_addr_i), .spi_cmd_o(spi_cmd_o), .spi_status_o(spi_status_o),
      .spi_enable_o(spi_enable_o), .spi_r1_i(spi_r1_i), .spi_flag_i(spi_flag_i),
      .spi_data_i(spi_data_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o),
      .init_done_o(init_done_o), .error_o(error_o), .err_code_o(err_code_o)
   );

   sd_cmd_sequencer #(.RETRY_MAX(16'd4), .TIMEOUT_CYC(24'd100)) dut_to (
      .spi_clk_i(spi_clk_i), .spi_rst_i(spi_rst_i), .start_i(b_start), .rd_req_i(b_rd_req),
      .rd_addr_i(b_addr), .spi_cmd_o(b_cmd), .spi_status_o(b_status),
      .spi_enable_o(b_enable), .spi_r1_i(b_r1), .spi_flag_i(b_flag),
      .spi_data_i(b_data_in), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .busy_o(b_busy),
      .init_done_o(b_init_done), .error_o(b_error), .err_code_o(b_err_code)
   );

   // card + master model: answers each enabled transaction with a scripted R1
   initial begin : card_model
      logic [47:0] c;
      spi_flag_i = 3'b000;
      spi_r1_i   = 8'h00;
      spi_data_i = 32'h0;
      acmd_run   = 0;
      forever begin
         @(negedge spi_clk_i);
         if (spi_enable_o) begin
            c = spi_cmd_o;
            cmd_log.push_back(c);
            if (c[47:40] == 8'hFF) acmd_run = 0;
            repeat (2) @(negedge spi_clk_i);
            if (c[47:40] == 8'h51)
               for (int i = 0; i < 128 && spi_enable_o; i++) begin
                  spi_data_i    = i;
                  spi_flag_i[0] = 1'b1;
                  @(negedge spi_clk_i);
                  spi_flag_i[0] = 1'b0;
                  @(negedge spi_clk_i);
               end
            if (spi_enable_o) begin
               spi_r1_i = c[47:40] == 8'h40 ? 8'h01 :
                          c[47:40] == 8'h48 ? cmd8_r1 :
                          c[47:40] == 8'h77 ? 8'h01 :
                          c[47:40] == 8'h69 ? (acmd_run < acmd_fails ? 8'h01 : 8'h00) :
                          c[47:40] == 8'h51 ? 8'h00 : 8'hFF;
               if (c[47:40] == 8'h69) acmd_run++;
               spi_flag_i[1] = 1'b1;
            end
            while (spi_enable_o) @(negedge spi_clk_i);
            spi_flag_i[1] = 1'b0;
         end
      end
   end

   // collect every strobed read word
   always @(negedge spi_clk_i) if (rd_valid_o) rd_words.push_back(rd_data_o);

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge spi_clk_i);
      start_i = 1'b0;
   endtask

   task automatic pulse_rd(input logic [31:0] addr);
      rd_addr_i = addr;
      rd_req_i  = 1'b1;
      @(negedge spi_clk_i);
      rd_req_i  = 1'b0;
      rd_addr_i = 32'hDEAD_BEEF;
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      int n = 0;
      while (busy_o && n < lim) begin
         @(negedge spi_clk_i);
         n++;
      end
      ok = !busy_o;
   endtask

   task automatic test_reset();
      spi_rst_i = 1'b1;
      @(negedge spi_clk_i);
      tests_run++; if (spi_cmd_o !== C_DUMMY) begin tests_failed++; $display("FAIL reset_cmd got %h want %h", spi_cmd_o, C_DUMMY); end
      tests_run++; if (spi_status_o !== 8'h84) begin tests_failed++; $display("FAIL reset_status got %h want 84", spi_status_o); end
      tests_run++; if (spi_enable_o !== 1'b0 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_en_busy got %b%b want 00", spi_enable_o, busy_o); end
      tests_run++; if ({init_done_o, error_o, err_code_o} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got %b want 00000", {init_done_o, error_o, err_code_o}); end
      tests_run++; if ({rd_valid_o, rd_data_o} !== 33'b0) begin tests_failed++; $display("FAIL reset_rd got %h want 0", {rd_valid_o, rd_data_o}); end
      spi_rst_i = 1'b0;
      @(negedge spi_clk_i);
   endtask

   task automatic test_init();
      logic [47:0] exp[11];
      int base = cmd_log.size();
      bit ok;
      exp[0] = C_DUMMY; exp[1] = C_CMD0; exp[2] = C_CMD8;
      for (int k = 0; k < 4; k++) begin exp[3+2*k] = C_CMD55; exp[4+2*k] = C_ACMD41; end
      acmd_fails = 3;
      pulse_start();
      repeat (4) @(negedge spi_clk_i);
      pulse_start();
      wait_idle(3000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL init_finish busy=%b want 0", busy_o); end
      tests_run++; if (cmd_log.size() - base !== 11) begin tests_failed++; $display("FAIL init_txn_count got %0d want 11", cmd_log.size() - base); end
      for (int k = 0; k < 11 && base + k < cmd_log.size(); k++) begin
         tests_run++;
         if (cmd_log[base+k] !== exp[k]) begin tests_failed++; $display("FAIL init_cmd[%0d] got %h want %h", k, cmd_log[base+k], exp[k]); end
      end
      tests_run++; if ({init_done_o, error_o} !== 2'b10) begin tests_failed++; $display("FAIL init_flags done/err got %b want 10", {init_done_o, error_o}); end
      tests_run++; if (spi_status_o[7:5] !== 3'b001 || spi_status_o[0] !== 1'b0) begin tests_failed++; $display("FAIL init_div status got %h want div 001 op 0", spi_status_o); end
   endtask

   task automatic test_read();
      int base_w = rd_words.size();
      int n = 0, bad = -1;
      bit ok;
      pulse_rd(32'h0000_0010);
      while (!spi_enable_o && n < 20) begin @(negedge spi_clk_i); n++; end
      tests_run++; if (spi_enable_o !== 1'b1) begin tests_failed++; $display("FAIL read_enable got %b want 1", spi_enable_o); end
      tests_run++; if (spi_cmd_o !== 48'h51_0000_0010_FF) begin tests_failed++; $display("FAIL read_cmd got %h want 510000_0010FF", spi_cmd_o); end
      tests_run++; if (spi_status_o !== 8'h35) begin tests_failed++; $display("FAIL read_status got %h want 35", spi_status_o); end
      wait_idle(1000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL read_finish busy=%b want 0", busy_o); end
      tests_run++; if (rd_words.size() - base_w !== 128) begin tests_failed++; $display("FAIL read_words got %0d want 128", rd_words.size() - base_w); end
      for (int i = 0; i < 128 && base_w + i < rd_words.size(); i++)
         if (bad < 0 && rd_words[base_w+i] !== 32'(i)) bad = i;
      tests_run++; if (bad >= 0) begin tests_failed++; $display("FAIL read_order word %0d got %h want %h", bad, rd_words[base_w+bad], bad); end
      tests_run++; if ({init_done_o, error_o} !== 2'b10) begin tests_failed++; $display("FAIL read_ready done/err got %b want 10", {init_done_o, error_o}); end
   endtask

   task automatic test_start_wins();
      int base = cmd_log.size();
      int n51 = 0;
      bit ok;
      acmd_fails = 0;
      start_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = 32'h0;
      @(negedge spi_clk_i);
      start_i = 1'b0; rd_req_i = 1'b0;
      wait_idle(2000, ok);
      for (int k = base; k < cmd_log.size(); k++) if (cmd_log[k][47:40] == 8'h51) n51++;
      tests_run++; if (!ok || cmd_log.size() - base !== 5) begin tests_failed++; $display("FAIL start_wins_txns got %0d want 5", cmd_log.size() - base); end
      tests_run++; if (n51 !== 0) begin tests_failed++; $display("FAIL start_wins_no_cmd17 got %0d want 0", n51); end
      tests_run++; if (cmd_log.size() > base && cmd_log[base] !== C_DUMMY) begin tests_failed++; $display("FAIL start_wins_first got %h want %h", cmd_log[base], C_DUMMY); end
      tests_run++; if (init_done_o !== 1'b1) begin tests_failed++; $display("FAIL start_wins_done got %b want 1", init_done_o); end
   endtask

   task automatic test_cmd8_error();
      int base = cmd_log.size();
      bit ok;
      cmd8_r1 = 8'h05;
      pulse_start();
      tests_run++; if (init_done_o !== 1'b0) begin tests_failed++; $display("FAIL cmd8_done_cleared got %b want 0", init_done_o); end
      wait_idle(1000, ok);
      tests_run++; if (!ok || {error_o, err_code_o} !== 4'b1_010) begin tests_failed++; $display("FAIL cmd8_err got %b/%0d want 1/2", error_o, err_code_o); end
      tests_run++; if (cmd_log.size() - base !== 3) begin tests_failed++; $display("FAIL cmd8_txns got %0d want 3", cmd_log.size() - base); end
      pulse_rd(32'h0000_0040);
      repeat (30) @(negedge spi_clk_i);
      tests_run++; if (cmd_log.size() - base !== 3 || spi_enable_o !== 1'b0) begin tests_failed++; $display("FAIL cmd8_quiet txns %0d en %b want 3 0", cmd_log.size() - base, spi_enable_o); end
      tests_run++; if ({busy_o, error_o} !== 2'b01) begin tests_failed++; $display("FAIL cmd8_hold busy/err got %b want 01", {busy_o, error_o}); end
      cmd8_r1 = 8'h01;
   endtask

   task automatic test_acmd41_timeout();
      int base = cmd_log.size();
      int na = 0;
      bit ok;
      acmd_fails = 1000;
      pulse_start();
      tests_run++; if ({busy_o, error_o, err_code_o} !== 5'b10_000) begin tests_failed++; $display("FAIL acmd_restart busy/err/code got %b want 10000", {busy_o, error_o, err_code_o}); end
      wait_idle(3000, ok);
      for (int k = base; k < cmd_log.size(); k++) if (cmd_log[k] == C_ACMD41) na++;
      tests_run++; if (na !== 4) begin tests_failed++; $display("FAIL acmd_attempts got %0d want 4", na); end
      tests_run++; if (!ok || {error_o, err_code_o} !== 4'b1_011) begin tests_failed++; $display("FAIL acmd_err got %b/%0d want 1/3", error_o, err_code_o); end
      tests_run++; if (init_done_o !== 1'b0) begin tests_failed++; $display("FAIL acmd_done got %b want 0", init_done_o); end
   endtask

   task automatic test_txn_timeout();
      int n = 0;
      b_start = 1'b1;
      @(negedge spi_clk_i);
      b_start = 1'b0;
      while (!b_enable && n < 10) begin @(negedge spi_clk_i); n++; end
      tests_run++; if (b_enable !== 1'b1 || b_cmd !== C_DUMMY || b_status !== 8'h87) begin tests_failed++; $display("FAIL to_dummy en %b cmd %h status %h want 1 %h 87", b_enable, b_cmd, b_status, C_DUMMY); end
      n = 0;
      while (!b_error && n < 300) begin @(negedge spi_clk_i); n++; end
      tests_run++; if (n !== 100) begin tests_failed++; $display("FAIL to_cycles got %0d want 100", n); end
      tests_run++; if (b_err_code !== 3'd6 || b_enable !== 1'b0 || b_busy !== 1'b0) begin tests_failed++; $display("FAIL to_state code %0d en %b busy %b want 6 0 0", b_err_code, b_enable, b_busy); end
   endtask

   task automatic test_reset_mid_read();
      int base;
      bit ok;
      acmd_fails = 0;
      pulse_start();
      wait_idle(2000, ok);
      tests_run++; if (!ok || init_done_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_init done got %b want 1", init_done_o); end
      pulse_rd(32'h0000_0020);
      repeat (60) @(negedge spi_clk_i);
      tests_run++; if ({busy_o, spi_enable_o} !== 2'b11) begin tests_failed++; $display("FAIL rst_mid busy/en got %b want 11", {busy_o, spi_enable_o}); end
      #2 spi_rst_i = 1'b1;
      #1;
      tests_run++; if (a_obs !== RST_VEC) begin tests_failed++; $display("FAIL rst_async outputs got %h want %h", a_obs, RST_VEC); end
      @(negedge spi_clk_i);
      spi_rst_i = 1'b0;
      @(negedge spi_clk_i);
      base = cmd_log.size();
      pulse_start();
      wait_idle(2000, ok);
      tests_run++; if (cmd_log.size() <= base || cmd_log[base] !== C_DUMMY) begin tests_failed++; $display("FAIL rst_rerun_first size %0d want >%0d starting with %h", cmd_log.size(), base, C_DUMMY); end
      tests_run++; if (!ok || {init_done_o, error_o} !== 2'b10) begin tests_failed++; $display("FAIL rst_rerun_done done/err got %b want 10", {init_done_o, error_o}); end
   endtask

   initial begin
      @(negedge spi_clk_i);
      test_reset();
      test_init();
      test_read();
      test_start_wins();
      test_cmd8_error();
      test_acmd41_timeout();
      test_txn_timeout();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule
